imm_decode_pipe: RTL and testbench

//  Pipelined, self-decoding immediate unit for the decode stage: accepts raw RV instructions with

---
 rtl/imm_pkg.sv | 26 ++
 rtl/imm_extract.sv | 76 +++++++
 rtl/imm_decode_pipe.sv | 110 +++++++++++
 tb/tb_imm_decode_pipe.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Shared constants for the immediate decode unit: immediate type codes and RV base opcodes.
// Optional feature macro used by dependants: IMM_DECODE_CSR_UIMM_EN.
package imm_pkg;

    localparam logic [2:0] IMM_J    = 3'b000;
    localparam logic [2:0] IMM_I    = 3'b001;
    localparam logic [2:0] IMM_S    = 3'b010;
    localparam logic [2:0] IMM_B    = 3'b011;
    localparam logic [2:0] IMM_U    = 3'b100;
    localparam logic [2:0] IMM_CSR  = 3'b101;
    localparam logic [2:0] IMM_NONE = 3'b111;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

endpackage

// File: rtl/imm_extract.sv
// Combinational opcode classifier and immediate extractor (XLEN 32 or 64).
// IMM_DECODE_CSR_UIMM_EN enables the CSR-immediate (uimm) format for SYSTEM opcodes.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      imm_type_o,
    output logic            illegal_o
);

    logic [31:0] imm32;

    always_comb begin
        imm32      = '0;
        imm_type_o = IMM_NONE;
        illegal_o  = 1'b0;
        case (instr_i[6:0])
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
                imm_type_o = IMM_I;
                imm32      = {{20{instr_i[31]}}, instr_i[31:20]};
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    imm_type_o = IMM_I;
                    imm32      = {{20{instr_i[31]}}, instr_i[31:20]};
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_STORE: begin
                imm_type_o = IMM_S;
                imm32      = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            end
            OPC_BRANCH: begin
                imm_type_o = IMM_B;
                imm32      = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                              instr_i[30:25], instr_i[11:8], 1'b0};
            end
            OPC_JAL: begin
                imm_type_o = IMM_J;
                imm32      = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                              instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                imm_type_o = IMM_U;
                imm32      = {instr_i[31:12], 12'b0};
            end
            OPC_OP: begin
            end
            OPC_OP_32: begin
                if (XLEN != 64) begin
                    illegal_o = 1'b1;
                end
            end
            OPC_SYSTEM: begin
`ifdef IMM_DECODE_CSR_UIMM_EN
                // funct3[2] selects the immediate CSR forms; uimm lives in the rs1 field
                if (instr_i[14]) begin
                    imm_type_o = IMM_CSR;
                    imm32      = {27'b0, instr_i[19:15]};
                end
`endif
            end
            default: begin
                illegal_o = 1'b1;
            end
        endcase
    end

    // CSR uimm has bit 31 clear, so a single sign extension serves every format
    assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_pipe.sv
// Pipelined immediate decode: valid/ready in, output register plus one skid entry, pc+imm target.
// Optional CSR-uimm decoding is enabled with the macro IMM_DECODE_CSR_UIMM_EN.
module imm_decode_pipe
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_imm_type,
    output logic [XLEN-1:0] out_target,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode_pipe: XLEN must be 32 or 64");
    end

    // Handshake: a transfer happens on a port when valid and ready are both high at the
    // rising edge; in_ready depends only on registered state (skid empty).
    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] pc;
        logic [2:0]      imm_type;
        logic            illegal;
    } entry_t;

    localparam entry_t ENTRY_RST = '{imm: '0, target: '0, pc: '0, imm_type: IMM_NONE, illegal: 1'b0};

    entry_t          in_entry, out_q, out_d, skid_q, skid_d;
    logic            out_valid_q, out_valid_d, skid_valid_q, skid_valid_d;
    logic [XLEN-1:0] ext_imm;
    logic [2:0]      ext_type;
    logic            ext_illegal;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .instr_i    (in_instr),
        .imm_o      (ext_imm),
        .imm_type_o (ext_type),
        .illegal_o  (ext_illegal)
    );

    always_comb begin
        in_entry.imm      = ext_imm;
        in_entry.target   = in_pc + ext_imm;
        in_entry.pc       = in_pc;
        in_entry.imm_type = ext_type;
        in_entry.illegal  = ext_illegal;
    end

    assign in_ready = !skid_valid_q;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output slot frees up: oldest entry (skid first) moves in; in_ready is high when skid empty
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = 1'b0;
            end else if (in_valid) begin
                out_d       = in_entry;
                out_valid_d = 1'b1;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_valid && in_ready) begin
            skid_d       = in_entry;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= ENTRY_RST;
            skid_q       <= ENTRY_RST;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_imm      = out_q.imm;
    assign out_imm_type = out_q.imm_type;
    assign out_target   = out_q.target;
    assign out_pc       = out_q.pc;
    assign out_illegal  = out_q.illegal;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: XLEN=32 and XLEN=64 instances share stimulus; a queue-based
// model checks both every cycle, and directed vectors pin literal expectations.
module tb_imm_decode_pipe;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        in_ready32, out_valid32, ill32;
    logic [31:0] imm32, tgt32, pc32;
    logic [2:0]  ty32;
    logic        in_ready64, out_valid64, ill64;
    logic [63:0] imm64, tgt64, pc64;
    logic [2:0]  ty64;

    int n_vec  = 0;
    int n_fail = 0;
    bit checking = 1'b0;
    bit fresh    = 1'b1;

    logic [95:0] exp_q[$];

    always #5 clk = ~clk;

    imm_decode_pipe #(.XLEN(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(imm32), .out_imm_type(ty32),
        .out_target(tgt32), .out_pc(pc32), .out_illegal(ill32)
    );

    imm_decode_pipe #(.XLEN(64)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(imm64), .out_imm_type(ty64),
        .out_target(tgt64), .out_pc(pc64), .out_illegal(ill64)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Immediate value computed arithmetically from the field layout of each format
    function automatic void model(input logic [31:0] ins, input logic [63:0] pc, input bit is64,
                                  output logic [63:0] imm, output logic [2:0] ty,
                                  output logic ill, output logic [63:0] tgt);
        longint v;
        v   = 0;
        ty  = 3'b111;
        ill = 1'b0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin ty = 3'b001; v = longint'(signed'(ins) >>> 20); end
            7'h1B: begin
                if (is64) begin ty = 3'b001; v = longint'(signed'(ins) >>> 20); end
                else ill = 1'b1;
            end
            7'h23: begin ty = 3'b010; v = longint'(signed'(ins) >>> 25) * 32 + longint'(ins[11:7]); end
            7'h63: begin
                ty = 3'b011;
                v  = (ins[31] ? longint'(-4096) : longint'(0)) + longint'(ins[7]) * 2048
                     + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            end
            7'h6F: begin
                ty = 3'b000;
                v  = (ins[31] ? longint'(-1048576) : longint'(0)) + longint'(ins[19:12]) * 4096
                     + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            end
            7'h37, 7'h17: begin ty = 3'b100; v = longint'(signed'(ins & 32'hFFFFF000)); end
            7'h33: ;
            7'h3B: if (!is64) ill = 1'b1;
            7'h73: begin
`ifdef IMM_DECODE_CSR_UIMM_EN
                if (ins[14]) begin ty = 3'b101; v = longint'(ins[19:15]); end
`endif
            end
            default: ill = 1'b1;
        endcase
        imm = is64 ? 64'(v) : {32'h0, v[31:0]};
        tgt = pc + imm;
        if (!is64) tgt = {32'h0, tgt[31:0]};
    endfunction

    always @(negedge clk) begin
        if (checking) begin : compare
            logic [63:0] e_imm, e_tgt, fp;
            logic [31:0] fi;
            logic [2:0]  e_ty;
            logic        e_ill;
            bit          rdy, ov;
            rdy = exp_q.size() < 2;
            ov  = exp_q.size() > 0;
            chk("in_ready32", in_ready32, rdy);
            chk("in_ready64", in_ready64, rdy);
            chk("out_valid32", out_valid32, ov);
            chk("out_valid64", out_valid64, ov);
            if (ov) begin
                {fi, fp} = exp_q[0];
                model(fi, fp, 1'b0, e_imm, e_ty, e_ill, e_tgt);
                chk("imm32", imm32, e_imm);
                chk("type32", ty32, e_ty);
                chk("illegal32", ill32, e_ill);
                chk("target32", tgt32, e_tgt);
                chk("pc32", pc32, fp[31:0]);
                model(fi, fp, 1'b1, e_imm, e_ty, e_ill, e_tgt);
                chk("imm64", imm64, e_imm);
                chk("type64", ty64, e_ty);
                chk("illegal64", ill64, e_ill);
                chk("target64", tgt64, e_tgt);
                chk("pc64", pc64, fp);
            end else if (fresh) begin
                chk("rst_imm32", imm32, 0);
                chk("rst_type32", ty32, 3'b111);
                chk("rst_tgt32", tgt32, 0);
                chk("rst_pc32", pc32, 0);
                chk("rst_ill32", ill32, 0);
                chk("rst_imm64", imm64, 0);
                chk("rst_type64", ty64, 3'b111);
                chk("rst_tgt64", tgt64, 0);
                chk("rst_pc64", pc64, 0);
                chk("rst_ill64", ill64, 0);
            end
            if (rst) begin
                exp_q.delete();
                fresh = 1'b1;
            end else if (flush) begin
                exp_q.delete();
            end else begin
                if (ov && out_ready) void'(exp_q.pop_front());
                if (in_valid && rdy) begin
                    exp_q.push_back({in_instr, in_pc});
                    fresh = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] ins, input logic [63:0] pc);
        bit ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready32;
            step();
        end
        in_valid = 1'b0;
        chk("push_accept", ok, 1);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 20 && out_valid32; i++) step();
        chk("drain_idle", out_valid32, 0);
    endtask

    logic [31:0] stream_v[8] = '{32'h00A50513, 32'hFFC52283, 32'hFE112E23, 32'h00B50463,
                                 32'hFF5FF06F, 32'h12345037, 32'h0010009B, 32'h0000003B};

    logic [31:0] mix_v[14] = '{32'h00008067, 32'hFFFFF017, 32'h40B50533, 32'h00000073,
                               32'h30002573, 32'h0001E073, 32'h12345678, 32'hFFFFFFFF,
                               32'h8000006F, 32'h80000063, 32'h80000023, 32'h7FF00013,
                               32'h3400D073, 32'h0010009B};

    initial begin
        int idx, cyc;
        bit ok;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_instr = '0; in_pc = '0;
        step();
        checking = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Directed literal vectors, out_ready held high
        push(32'hFFF00093, 64'h100);
        chk("addi_valid", out_valid32, 1);
        chk("addi_imm32", imm32, 32'hFFFFFFFF);
        chk("addi_type", ty32, 3'b001);
        chk("addi_tgt32", tgt32, 32'h000000FF);
        chk("addi_ill", ill32, 0);
        chk("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
        push(32'hFE000EE3, 64'h2000);
        chk("beq_imm32", imm32, 32'hFFFFFFFC);
        chk("beq_type", ty32, 3'b011);
        chk("beq_tgt32", tgt32, 32'h00001FFC);
        push(32'h0000006F, 64'h0);
        chk("jal_imm32", imm32, 0);
        chk("jal_type", ty32, 3'b000);
        push(32'h800000B7, 64'h0);
        chk("lui_imm64", imm64, 64'hFFFFFFFF80000000);
        chk("lui_imm32", imm32, 32'h80000000);
        chk("lui_type", ty64, 3'b100);
        push(32'h00000000, 64'h40);
        chk("zero_ill", ill32, 1);
        chk("zero_imm", imm32, 0);
        chk("zero_type", ty32, 3'b111);
        chk("zero_tgt", tgt32, 32'h40);
        push(32'h0000707B, 64'h44);
        chk("x7b_ill32", ill32, 1);
        chk("x7b_type32", ty32, 3'b111);
        push(32'h00000033, 64'h48);
        chk("op_type", ty32, 3'b111);
        chk("op_ill", ill32, 0);
        push(32'h3400D073, 64'h50);
`ifdef IMM_DECODE_CSR_UIMM_EN
        chk("csr_type", ty32, 3'b101);
        chk("csr_imm", imm32, 1);
        chk("csr_tgt", tgt32, 32'h51);
`else
        chk("csr_type", ty32, 3'b111);
        chk("csr_imm", imm32, 0);
        chk("csr_tgt", tgt32, 32'h50);
`endif
        drain();

        // Back-to-back stream of 8 with out_ready low in cycles 3..5
        idx = 0;
        cyc = 0;
        while (cyc < 40 && idx < 8) begin
            out_ready = !(cyc >= 3 && cyc <= 5);
            in_valid  = 1'b1;
            in_instr  = stream_v[idx];
            in_pc     = 64'h1000 + 64'(idx) * 4;
            ok        = in_ready32;
            step();
            if (ok) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("stream_count", idx, 8);
        chk("stream_cycles", cyc, 11);
        drain();

        // Flush with both entries buffered and a pending input
        out_ready = 1'b0;
        push(32'h00100093, 64'h3000);
        push(32'h00200093, 64'h3004);
        chk("full_ready", in_ready32, 0);
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00300093; in_pc = 64'h3008;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", out_valid32, 0);
        chk("flush_ready", in_ready32, 1);
        // Flush while the input would be accepted: that entry is dropped
        push(32'h00400093, 64'h300C);
        out_ready = 1'b1;
        flush = 1'b1; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 64'h3010;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush2_valid", out_valid32, 0);
        step();
        step();
        chk("flush2_nodrop", out_valid32, 0);

        // Reset mid-stream
        out_ready = 1'b0;
        push(32'hFFF00093, 64'h4000);
        push(32'hFE000EE3, 64'h4004);
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'h0000006F; in_pc = 64'h4008;
        step();
        rst = 1'b0; in_valid = 1'b0;
        chk("mrst_valid", out_valid32, 0);
        chk("mrst_ready", in_ready32, 1);
        chk("mrst_imm", imm32, 0);
        chk("mrst_type", ty32, 3'b111);
        chk("mrst_pc64", pc64, 0);

        // Mixed opcodes under a randomly stalling consumer
        idx = 0;
        cyc = 0;
        while (cyc < 300 && idx < 14) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = 1'b1;
            in_instr  = mix_v[idx];
            in_pc     = 64'hFFFF_FFFF_FFFF_FF00 + 64'(idx) * 8;
            ok        = in_ready32;
            step();
            if (ok) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        chk("mix_count", idx, 14);
        drain();

        checking = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
